// File: rtl/serial_xor_arbiter.sv
// Two-requester round-robin arbiter feeding a bit-serial XOR engine.
// One mux-built XOR gate is reused LSB-first over WIDTH cycles per operation.

module mux_xor (
  input  logic a_i,
  input  logic b_i,
  output logic y_o
);
  // a selects between b and its complement, which is a XOR b.
  assign y_o = a_i ? ~b_i : b_i;
endmodule

module serial_xor_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_id
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic             res_id_q, res_id_d;
  logic             last_q, last_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic gnt0, gnt1;
  logic bit_x;

  // On a tie the requester that was not served last wins.
  assign gnt0 = req0_valid && (!req1_valid || last_q);
  assign gnt1 = req1_valid && (!req0_valid || !last_q);

  assign req0_ready = (state_q == IDLE) && !rst && gnt0;
  assign req1_ready = (state_q == IDLE) && !rst && gnt1;

  mux_xor u_xor (
    .a_i (a_q[cnt_q]),
    .b_i (b_q[cnt_q]),
    .y_o (bit_x)
  );

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    res_data_d = res_data_q;
    res_id_d   = res_id_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    case (state_q)
      IDLE: begin
        if (req0_ready) begin
          a_d      = req0_a;
          b_d      = req0_b;
          res_id_d = 1'b0;
          last_d   = 1'b0;
          cnt_d    = '0;
          state_d  = CALC;
        end else if (req1_ready) begin
          a_d      = req1_a;
          b_d      = req1_b;
          res_id_d = 1'b1;
          last_d   = 1'b1;
          cnt_d    = '0;
          state_d  = CALC;
        end
      end
      CALC: begin
        res_data_d[cnt_q] = bit_x;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      res_data_q <= '0;
      res_id_q   <= 1'b0;
      last_q     <= 1'b1;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      res_data_q <= res_data_d;
      res_id_q   <= res_id_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
    end
  end

  assign res_valid = (state_q == DONE);
  assign res_data  = res_data_q;
  assign res_id    = res_id_q;

endmodule
